// File: rtl/commit_shadow_stack.sv
// Commit-time shadow return-address stack.
// Calls retired at commit push their link address; returns pop and compare the
// popped address against the resolved target. A mismatch traps until the
// controller acknowledges it, after which the stack restarts empty.
module commit_shadow_stack #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned VLEN            = 64,
    parameter logic [63:0] CFI_CAUSE       = 64'h18
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      en_i,
    input  logic [NR_COMMIT_PORTS-1:0]                commit_ack_i,
    input  logic [NR_COMMIT_PORTS-1:0]                is_call_i,
    input  logic [NR_COMMIT_PORTS-1:0]                is_ret_i,
    input  logic [NR_COMMIT_PORTS-1:0][VLEN-1:0]      link_addr_i,
    input  logic [NR_COMMIT_PORTS-1:0][VLEN-1:0]      ret_target_i,
    input  logic                                      ex_ack_i,
    output logic                                      ex_valid_o,
    output logic [63:0]                               ex_cause_o,
    output logic [VLEN-1:0]                           ex_tval_o,
    output logic [$clog2(DEPTH):0]                    depth_o,
    output logic [15:0]                               ovf_cnt_o,
    output logic [15:0]                               unf_cnt_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {StRun, StTrap} state_e;

    state_e                               state_q, state_d;
    logic [PtrW-1:0]                      ptr_q, ptr_d;     // next free slot
    logic [CntW-1:0]                      cnt_q, cnt_d;
    logic [15:0]                          ovf_q, ovf_d;
    logic [15:0]                          unf_q, unf_d;
    logic [VLEN-1:0]                      tval_q, tval_d;
    logic [VLEN-1:0]                      mem_q [DEPTH];

    // Per-port write requests produced by the sequential port walk below
    logic [NR_COMMIT_PORTS-1:0]           wr_en;
    logic [NR_COMMIT_PORTS-1:0][PtrW-1:0] wr_idx;
    logic [NR_COMMIT_PORTS-1:0][VLEN-1:0] wr_data;
    logic [PtrW-1:0]                      top_idx;
    logic [VLEN-1:0]                      top_val;
    logic                                 viol;

    // Next-state: walk commit ports in order, each seeing the effect of earlier ports
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        tval_d  = tval_q;
        wr_en   = '0;
        wr_idx  = '0;
        wr_data = '0;
        top_idx = '0;
        top_val = '0;
        viol    = 1'b0;
        unique case (state_q)
            StRun: begin
                if (en_i) begin
                    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
                        if (commit_ack_i[p] && !viol) begin
                            if (is_ret_i[p]) begin
                                if (cnt_d != '0) begin
                                    top_idx = ptr_d - 1'b1;
                                    top_val = mem_q[top_idx];
                                    // Forward a link pushed by an earlier port this cycle
                                    for (int w = 0; w < NR_COMMIT_PORTS; w++) begin
                                        if (wr_en[w] && wr_idx[w] == top_idx) begin
                                            top_val = wr_data[w];
                                        end
                                    end
                                    if (top_val != ret_target_i[p]) begin
                                        viol    = 1'b1;
                                        tval_d  = ret_target_i[p];
                                        state_d = StTrap;
                                    end
                                    ptr_d = top_idx;
                                    cnt_d = cnt_d - 1'b1;
                                end else if (unf_d != 16'hFFFF) begin
                                    unf_d = unf_d + 16'd1;
                                end
                            end
                            if (is_call_i[p] && !viol) begin
                                wr_en[p]   = 1'b1;
                                wr_idx[p]  = ptr_d;
                                wr_data[p] = link_addr_i[p];
                                ptr_d      = ptr_d + 1'b1;
                                // Full stack: slot at ptr was the oldest entry
                                if (cnt_d == CntW'(DEPTH)) begin
                                    if (ovf_d != 16'hFFFF) ovf_d = ovf_d + 16'd1;
                                end else begin
                                    cnt_d = cnt_d + 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            StTrap: begin
                if (ex_ack_i) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    tval_d  = '0;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StRun;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= '0;
            unf_q   <= '0;
            tval_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            tval_q  <= tval_d;
        end
    end

    // Entry storage; contents are meaningless until pushed, so no reset
    always_ff @(posedge clk_i) begin
        for (int w = 0; w < NR_COMMIT_PORTS; w++) begin
            if (wr_en[w]) mem_q[wr_idx[w]] <= wr_data[w];
        end
    end

    // Outputs come straight from registered state so reset clears them immediately
    always_comb begin
        ex_valid_o = (state_q == StTrap);
        ex_cause_o = (state_q == StTrap) ? CFI_CAUSE : 64'd0;
        ex_tval_o  = tval_q;
        depth_o    = cnt_q;
        ovf_cnt_o  = ovf_q;
        unf_cnt_o  = unf_q;
    end

endmodule

// File: doc/commit_shadow_stack.md
COMMIT_SHADOW_STACK -- requirements
Module: commit_shadow_stack

Interface
REQ-001 The block SHALL have parameter NR_COMMIT_PORTS, default 2, meaning the number of commit ports; only the value 2 is supported.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the number of shadow-stack entries; it SHALL be a power of two, at least 4.
REQ-003 The block SHALL have parameter VLEN, default 64, meaning the address width.
REQ-004 The block SHALL have parameter CFI_CAUSE, default 64'h18, meaning the cause value reported on a violation.
REQ-005 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high.
REQ-006 clk_i  in  1  clock.
REQ-007 rst_i  in  1  asynchronous active-high reset.
REQ-008 en_i  in  1  checker enable; when low, the stack is frozen and no violation is raised.
REQ-009 commit_ack_i  in  NR_COMMIT_PORTS  per-port commit acknowledge from the commit stage.
REQ-010 is_call_i  in  NR_COMMIT_PORTS  the committed instruction is a call (jal/jalr with rd=x1 or x5).
REQ-011 is_ret_i  in  NR_COMMIT_PORTS  the committed instruction is a return (jalr rs1=x1/x5, rd=x0).
REQ-012 link_addr_i  in  NR_COMMIT_PORTS x VLEN  return address pushed by a call.
REQ-013 ret_target_i  in  NR_COMMIT_PORTS x VLEN  resolved target of a return.
REQ-014 ex_ack_i  in  1  the controller has taken the exception.
REQ-015 ex_valid_o  out  1  CFI violation exception is pending.
REQ-016 ex_cause_o  out  64  exception cause, equal to CFI_CAUSE while ex_valid_o is high and 0 otherwise.
REQ-017 ex_tval_o  out  VLEN  offending return target.
REQ-018 depth_o  out  $clog2(DEPTH)+1  current number of valid entries.
REQ-019 ovf_cnt_o  out  16  saturating count of overflow events.
REQ-020 unf_cnt_o  out  16  saturating count of underflow events.

Function
REQ-021 The stack SHALL be a circular buffer with a top pointer wrapping modulo DEPTH and a count register saturating at DEPTH.
REQ-022 The state machine SHALL have two states, RUN and TRAP; reset SHALL enter RUN.
REQ-023 In RUN with en_i=1, the events of a cycle SHALL be processed in port order: port 0 first, then port 1. Only ports with commit_ack_i=1 are processed.
REQ-024 A call SHALL push link_addr_i. When the count equals DEPTH, the push SHALL overwrite the oldest entry, the count SHALL stay at DEPTH, and ovf_cnt_o SHALL increment.
REQ-025 A return with count>0 SHALL pop the top entry and compare it to ret_target_i; on mismatch the block SHALL raise a violation.
REQ-026 A return with count=0 SHALL not be checked, SHALL increment unf_cnt_o, and SHALL leave the pointer unchanged.
REQ-027 For port 0 call + port 1 return in the same cycle, port 1 SHALL compare against port 0's link_addr_i, and the net stack state SHALL be unchanged.
REQ-028 For port 0 return + port 1 call, the block SHALL pop and then push. Two calls SHALL give two pushes; two returns SHALL give two sequential pops and compares.
REQ-029 If port 0 raises a violation, port 1's event in that cycle SHALL be ignored.
REQ-030 A call flagged also as a return (is_call_i and is_ret_i both set) SHALL be treated as a pop-and-compare followed by a push.
REQ-031 On a violation in cycle N, the block SHALL enter TRAP at the edge ending cycle N, so that ex_valid_o=1 in cycle N+1, ex_tval_o equals the offending ret_target_i, and ex_cause_o equals CFI_CAUSE.
REQ-032 In TRAP, ex_valid_o, ex_cause_o and ex_tval_o SHALL be held stable and all commit events SHALL be ignored.
REQ-033 In TRAP, ex_ack_i=1 SHALL return the block to RUN at the next edge, clear the stack (count=0), and drop ex_valid_o in the following cycle. ex_ack_i in RUN SHALL be ignored.
REQ-034 en_i=0 SHALL block pushes, pops and counter updates, but SHALL NOT cancel a TRAP that is already pending.
REQ-035 The counters SHALL saturate at 16'hFFFF and SHALL never wrap.
REQ-036 depth_o SHALL reflect the registered count and SHALL update one cycle after the event.

Reset
REQ-037 While rst_i=1, the block SHALL asynchronously force state=RUN, count=0, pointer=0, ex_valid_o=0, ex_cause_o=0, ex_tval_o=0, ovf_cnt_o=0 and unf_cnt_o=0. Stack entry contents SHALL be don't-care.
REQ-038 Reset asserted in TRAP SHALL drop ex_valid_o immediately, without waiting for a clock edge.

Verification
REQ-039 Push/pop match: port 0 call with link 0x1004, a later port 0 return with target 0x1004 -> depth_o goes 1 then 0, ex_valid_o stays 0.
REQ-040 Mismatch: call with link 0x2008, then return with target 0x3000 -> in the next cycle ex_valid_o=1, ex_tval_o=0x3000, ex_cause_o=0x18. The outputs are held until ex_ack_i, then depth_o=0.
REQ-041 Dual-port forward: same cycle, port 0 call with link 0x40 and port 1 return with target 0x40 -> no violation, depth_o unchanged. Repeating with target 0x44 -> violation with ex_tval_o=0x44.
REQ-042 Overflow: 17 calls with DEPTH=16 -> depth_o=16, ovf_cnt_o=1. Then 16 matching returns -> no violation, and the 17th return gives unf_cnt_o=1.
REQ-043 Port-0 violation masks port 1: port 0 return mismatches while port 1 is a call -> the port 1 call is not pushed, and TRAP is entered.
REQ-044 Async reset in TRAP: assert rst_i mid-cycle -> ex_valid_o=0 before the next edge, and all counters read 0.
